// File: rtl/pwm_pkg.sv
// pwm_pkg: constants shared by the PWM capture block (and the PWM generator).
//   - default width, timeout and glitch-filter length
//   - FSM state encoding for pwm_capture (IDLE / ARM / RUN)
//   - the nominal PWM period used by the generator side of the link
package pwm_pkg;

  localparam int          W_DEF          = 16;
  localparam logic [15:0] TIMEOUT_DEF    = 16'hFFF0;
  localparam int          FILTER_LEN_DEF = 4;

  // Nominal generator period in clock_50 cycles (195).
  localparam logic [15:0] PWM_PERIOD     = 16'h00C3;

  // Capture FSM encoding.
  localparam logic [1:0]  ST_IDLE        = 2'd0;
  localparam logic [1:0]  ST_ARM         = 2'd1;
  localparam logic [1:0]  ST_RUN         = 2'd2;

endpackage

// File: rtl/pwm_in_sync.sv
// pwm_in_sync: brings the asynchronous PWM input into the clock_50 domain.
//   2-FF synchronizer, optional glitch filter, one sample stage (s) and
//   rising-edge detect on s.
// Configuration macro: PWM_CAPTURE_FILTER_EN enables the glitch filter; the
//   filtered level only changes after FILTER_LEN consecutive equal samples.
// Ports:
//   clock_50 in  system clock
//   clr      in  asynchronous active-high reset
//   pwm_in   in  raw asynchronous PWM input
//   s        out synchronized (filtered) level
//   rise     out one-cycle pulse while s is 1 and was 0 the cycle before
module pwm_in_sync
  import pwm_pkg::*;
`ifdef PWM_CAPTURE_FILTER_EN
  #(
    parameter int FILTER_LEN = FILTER_LEN_DEF
  )
`endif
  (
    input  logic clock_50,
    input  logic clr,
    input  logic pwm_in,
    output logic s,
    output logic rise
  );

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic s_q, s_d;
  logic s_prev_q, s_prev_d;
  logic s_src;

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          filt_q, filt_d;
  logic [CW-1:0] run_q, run_d;

  // run_q counts consecutive samples that disagree with the accepted level;
  // any agreeing sample restarts the count, so short glitches never win.
  always_comb begin
    filt_d = filt_q;
    run_d  = '0;
    if (sync2_q != filt_q) begin
      if (run_q == CW'(FILTER_LEN - 1)) begin
        filt_d = sync2_q;
      end else begin
        run_d = run_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_50 or posedge clr) begin
    if (clr) begin
      filt_q <= 1'b0;
      run_q  <= '0;
    end else begin
      filt_q <= filt_d;
      run_q  <= run_d;
    end
  end

  assign s_src = filt_q;
`else
  assign s_src = sync2_q;
`endif

  always_comb begin
    sync1_d  = pwm_in;
    sync2_d  = sync1_q;
    s_d      = s_src;
    s_prev_d = s_q;
  end

  always_ff @(posedge clock_50 or posedge clr) begin
    if (clr) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      s_q      <= 1'b0;
      s_prev_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      s_q      <= s_d;
      s_prev_q <= s_prev_d;
    end
  end

  assign s    = s_q;
  assign rise = s_q & ~s_prev_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform in clock_50 cycles.
//   Reports the high time (duty) and rising-edge-to-rising-edge period of the
//   last complete period, pulses valid when they update, and flags loss of
//   signal after TIMEOUT cycles without a rising edge.
// Configuration macro: PWM_CAPTURE_FILTER_EN adds a FILTER_LEN-sample glitch
//   filter on the input (adds FILTER_LEN cycles of latency, results unchanged).
// Ports:
//   clock_50  in  system clock
//   clr       in  asynchronous active-high reset
//   pwm_in    in  asynchronous PWM input
//   duty      out high-time cycles of the last complete period
//   period    out cycles between the last two rising edges
//   valid     out one-cycle pulse when duty/period update
//   no_signal out high after TIMEOUT cycles without a rising edge, or since reset
//   level     out current synchronized (filtered) input level
module pwm_capture
  import pwm_pkg::*;
  #(
    parameter int         W       = W_DEF,
    parameter logic [W-1:0] TIMEOUT = W'(TIMEOUT_DEF)
`ifdef PWM_CAPTURE_FILTER_EN
    ,
    parameter int         FILTER_LEN = FILTER_LEN_DEF
`endif
  )
  (
    input  logic         clock_50,
    input  logic         clr,
    input  logic         pwm_in,
    output logic [W-1:0] duty,
    output logic [W-1:0] period,
    output logic         valid,
    output logic         no_signal,
    output logic         level
  );

  localparam logic [W-1:0] CNT_MAX = '1;

  logic s, rise;

  pwm_in_sync
`ifdef PWM_CAPTURE_FILTER_EN
    #(.FILTER_LEN(FILTER_LEN))
`endif
    u_sync (
      .clock_50 (clock_50),
      .clr      (clr),
      .pwm_in   (pwm_in),
      .s        (s),
      .rise     (rise)
    );

  logic [1:0]   state_q, state_d;
  logic [W-1:0] cnt_p_q, cnt_p_d;
  logic [W-1:0] cnt_h_q, cnt_h_d;
  logic [W-1:0] duty_q, duty_d;
  logic [W-1:0] period_q, period_d;
  logic         valid_q, valid_d;
  logic         no_signal_q, no_signal_d;

  always_comb begin
    state_d     = state_q;
    cnt_p_d     = cnt_p_q;
    cnt_h_d     = cnt_h_q;
    duty_d      = duty_q;
    period_d    = period_q;
    valid_d     = 1'b0;
    no_signal_d = no_signal_q;

    // A rise starts a new period; the rise cycle itself counts as the
    // first cycle of both the period and the high phase.
    if (rise) begin
      cnt_p_d = W'(1);
      cnt_h_d = W'(1);
    end else begin
      if (cnt_p_q != CNT_MAX) cnt_p_d = cnt_p_q + 1'b1;
      if (s && (cnt_h_q != CNT_MAX)) cnt_h_d = cnt_h_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_ARM;
      end
      ST_ARM, ST_RUN: begin
        // The rise is checked first so it wins over a coincident timeout.
        if (rise) begin
          state_d     = ST_RUN;
          period_d    = cnt_p_q;
          duty_d      = cnt_h_q;
          valid_d     = 1'b1;
          no_signal_d = 1'b0;
        end else if (cnt_p_q == TIMEOUT) begin
          state_d     = ST_IDLE;
          no_signal_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_50 or posedge clr) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      cnt_p_q     <= '0;
      cnt_h_q     <= '0;
      duty_q      <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      no_signal_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_p_q     <= cnt_p_d;
      cnt_h_q     <= cnt_h_d;
      duty_q      <= duty_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      no_signal_q <= no_signal_d;
    end
  end

  assign duty      = duty_q;
  assign period    = period_q;
  assign valid     = valid_q;
  assign no_signal = no_signal_q;
  assign level     = s;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized and directed stimulus for pwm_capture, checked
// every cycle against an edge-list reference model (rise times, high-sample
// counts, elapsed cycles since the last rise) plus a queue of expected
// duty/period results consumed on each valid pulse.
// Build with PWM_CAPTURE_FILTER_EN to exercise the glitch-filter variant.
module tb_pwm_capture;
  import pwm_pkg::*;

  localparam int           W    = 16;
  localparam logic [W-1:0] TOUT = 16'd600;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FL    = 4;
  localparam int LAT   = 3 + FL;
  localparam int MINPH = FL + 2;
`else
  localparam int LAT   = 3;
  localparam int MINPH = 2;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic         clock_50 = 1'b0;
  logic         clr      = 1'b0;
  logic         pwm_in   = 1'b0;
  logic [W-1:0] duty, period;
  logic         valid, no_signal, level;

  always #10 clock_50 = ~clock_50;

  pwm_capture #(.W(W), .TIMEOUT(TOUT)) dut (
    .clock_50  (clock_50),
    .clr       (clr),
    .pwm_in    (pwm_in),
    .duty      (duty),
    .period    (period),
    .valid     (valid),
    .no_signal (no_signal),
    .level     (level)
  );

  // ---------------- reference model state ----------------
  logic [15:0]  hist;        // hist[j] = input sampled j clock edges ago
  int           k;           // clock edges since reset release
  int           seen;        // rises seen since reset/timeout, capped at 2
  int           last_rise;   // edge index at which the last rise was acted on
  int           high;        // high samples since the last rise
  logic [W-1:0] m_duty, m_period;
  logic         m_valid, m_nosig;
  logic [W-1:0] exp_q[$];    // expected duty, period pairs

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] got,
                          input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)",
               tag, got, exp, k, $time);
    end
  endtask

  // A rise in the input is acted on LAT edges after it is first sampled;
  // the model therefore evaluates the sample taken LAT edges ago.
  task automatic model_edge(input logic v, input logic rst);
    if (rst) begin
      hist = '0; k = 0; seen = 0; last_rise = 0; high = 0;
      m_duty = '0; m_period = '0; m_valid = 1'b0; m_nosig = 1'b1;
      exp_q.delete();
    end else begin
      k++;
      hist    = {hist[14:0], v};
      m_valid = 1'b0;
      if (hist[LAT] && !hist[LAT+1]) begin
        if (seen >= 1) begin
          m_duty   = W'(high);
          m_period = W'(k - last_rise);
          m_valid  = 1'b1;
          m_nosig  = 1'b0;
          exp_q.push_back(m_duty);
          exp_q.push_back(m_period);
        end
        if (seen < 2) seen++;
        last_rise = k;
        high      = 1;
      end else begin
        if (hist[LAT]) high++;
        if (seen >= 1 && (k - last_rise) == int'(TOUT)) begin
          seen    = 0;
          m_nosig = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0] e_d, e_p;
    check_eq("valid",     W'(valid),     W'(m_valid));
    check_eq("no_signal", W'(no_signal), W'(m_nosig));
    check_eq("level",     W'(level),     W'(hist[LAT-1]));
    check_eq("duty_hold", duty,          m_duty);
    check_eq("period_hold", period,      m_period);
    if (valid === 1'b1) begin
      if (exp_q.size() >= 2) begin
        e_d = exp_q.pop_front();
        e_p = exp_q.pop_front();
        check_eq("sb_duty",   duty,   e_d);
        check_eq("sb_period", period, e_p);
      end else begin
        check_eq("sb_underflow", W'(exp_q.size()), W'(2));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // v: intended level, g: glitch inverting the driven pin, rst: clr level
  task automatic step(input logic v, input logic g, input logic rst);
    @(negedge clock_50);
    clr    = rst;
    pwm_in = v ^ g;
    @(posedge clock_50);
    model_edge(v, rst);
    #1;
    check_outputs();
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) step(v, 1'b0, 1'b0);
  endtask

  task automatic pwm_cycles(input int h, input int l, input int reps);
    for (int r = 0; r < reps; r++) begin
      hold(1'b1, h);
      hold(1'b0, l);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int per;
    int h, l;
    per = int'(PWM_PERIOD);

    // Reset held with a toggling input.
    for (int i = 0; i < 5; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    hold(1'b0, 4);

    // Steady 50/145, then a duty change to 100/95 with the same period.
    pwm_cycles(50, per - 50, 5);
    pwm_cycles(100, per - 100, 3);

    // Stuck low long enough to time out, then recover.
    hold(1'b0, int'(TOUT) + 40);
    pwm_cycles(50, per - 50, 3);

    // clr pulsed in the middle of a high phase.
    hold(1'b1, 20);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    hold(1'b1, 27);
    hold(1'b0, per - 50);
    pwm_cycles(50, per - 50, 3);

`ifdef PWM_CAPTURE_FILTER_EN
    // Short glitches in the low phase must be invisible.
    for (int r = 0; r < 3; r++) begin
      hold(1'b1, 50);
      hold(1'b0, 60);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      hold(1'b0, per - 50 - 62);
    end
`endif

    // Randomized waveforms with occasional dropouts.
    for (int r = 0; r < 40; r++) begin
      h = $urandom_range(MINPH, 150);
      l = $urandom_range(MINPH, 150);
      pwm_cycles(h, l, $urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) hold(1'b0, $urandom_range(100, int'(TOUT) + 80));
    end

    hold(1'b0, LAT + 4);
    check_eq("sb_leftover", W'(exp_q.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
